bcd_display_scheduler: RTL
==========================

# bcd_display_scheduler

Sequences the 10-bit DPWM duty/count value through a multi-cycle binary-to-BCD conversion (shift-and-add-3, one iteration per clock) and drives a 4-digit multiplexed common-anode 7-segment display with the result. Sits between the DPWM control registers and the board display pins. It owns the conversion datapath, queues update requests that arrive mid-conversion, and time-multiplexes the digits with a programmable refresh prescaler.

## Interface
- REFRESH_DIV, 50000: clock cycles each digit stays lit; legal range 2..2^20.
- BLANK_LEADING, 1: 1 blanks leading zero digits (thousands, hundreds, tens); 0 shows all four.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- number  in  10  binary value to display, 0..1023.
- load  in  1  single-cycle request to convert `number`.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when new digits are committed.
- digits  out  16  committed BCD value {mil, hundreds, tens, ones}.
- an  out  4  anode enables, active-low, one-hot; an[0] = ones … an[3] = mil.
- seg  out  7  segments, active-low; seg[0]=a … seg[6]=g.
- dp  out  1  decimal point, active-low; constant 1 (off).

## Operation
- FSM states: IDLE, SHIFT, COMMIT.
  - IDLE + load: capture `number` into shift[9:0]; clear shift[25:10] and iteration counter; go to SHIFT.
  - SHIFT: each cycle, add 3 to every nibble of shift[25:10] (4 nibbles) that is >= 5, then shift the 26-bit register left by 1, all in the same cycle. Exactly 10 iterations, then go to COMMIT.
  - COMMIT: digits <= shift[25:10]; done = 1.
    - If pending is set: load the pending value, clear pending, go to SHIFT.
    - Otherwise go to IDLE.
- Request queue: one entry deep. A load seen in SHIFT or COMMIT stores `number` into the pending register and sets pending; a later load overwrites it (latest wins). A load in IDLE never sets pending.
- busy = (state != IDLE), decoded from the state register.
- digits changes only in COMMIT. The display never shows partial results.
- Scan:
  - Prescaler counts 0..REFRESH_DIV-1 continuously, independent of the FSM.
  - At terminal count it wraps to 0 and digit index idx advances 0→1→2→3→0.
  - an = ~(1 << idx).
- Segment decode of digits[4*idx+3:4*idx], active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000 (written g..a).
  - Nibbles 10–15 cannot occur; decode them as blank (1111111).
- Blanking, only when BLANK_LEADING=1:
  - Digit k (k = 1..3) shows 1111111 when it and every higher digit are zero.
  - Digit 0 is never blanked.
- Width rules:
  - Shift register 26 bits; add-3 is a 4-bit add with no carry into the next nibble.
  - mil is at most 1; no overflow is possible.

## Timing
- Reset values: state IDLE, busy 0, done 0, digits 16'h0000, pending 0, prescaler 0, idx 0, an 4'b1110, seg 7'b1000000, dp 1.
- Conversion latency, with load sampled at edge E0:
  - busy rises after E0.
  - Iterations occur on edges E1..E10.
  - Edge E11 commits digits and raises done for exactly one cycle (E11–E12).
  - busy falls after E12 if nothing is pending.
  - Next IDLE load is accepted at E12 at the earliest.
- Back-to-back: with pending set, COMMIT at E11 leads directly to SHIFT. The second done occurs at E22; busy stays high throughout.
- load held high in IDLE starts one conversion. If still high in later cycles, it queues again per the pending rules; the bench drives single-cycle pulses.
- an/seg change on the clock edge after the prescaler terminal count. seg and an come from the same registered idx, so they switch together with no skew.
- Reset mid-conversion returns everything to reset values immediately (asynchronous); the partial result and pending request are discarded.
- load and reset both asserted: reset wins.

## Test plan
- Reset: assert reset mid-scan → an=1110, seg=1000000, digits=0000, busy=0, done=0 with no clock edge.
- Full-scale: load number=1023 → busy 11 cycles, done pulse at E11, digits=16'h1023; with REFRESH_DIV=4, an walks 1110→1101→1011→0111 every 4 cycles with seg 0110000, 0100100, 1000000, 1111001.
- Blanking: load 0 → digits=0000; idx 1..3 seg=1111111, idx 0 seg=1000000. Repeat with BLANK_LEADING=0 → all four show 1000000.
- Queue: load 512, then load 300 at E3 and load 77 at E5 → done at E11 (digits=0512) and E22 (digits=0077). Display shows blank, blank, 7, 7; busy continuous until E23.
- Reset mid-conversion: load 999, assert reset at E5, release, load 45 → single done, digits=0045, no trace of 999.
- Exhaustive: load every value 0..1023 → digits equals the decimal value each time; done count equals 1024.

Source files
------------

// File: rtl/bcd_display_scheduler.sv
// bcd_display_scheduler
// Converts a 10-bit binary value to four BCD digits with a sequential
// shift-and-add-3 datapath (one iteration per clock). While a conversion
// runs, one further request is held in a single-entry queue where the latest
// request wins. The committed digits are time-multiplexed onto a 4-digit
// common-anode 7-segment display, and leading zeros can optionally be blanked.
module bcd_display_scheduler #(
    parameter int unsigned REFRESH_DIV   = 50000,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  number,
    input  logic        load,
    output logic        busy,
    output logic        done,
    output logic [15:0] digits,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [3:0]  LAST_ITER  = 4'd9;
    localparam logic [19:0] PRESC_LAST = 20'(REFRESH_DIV - 1);

    state_t      state;
    logic [25:0] shift;
    logic [25:0] shift_adj;
    logic [3:0]  iter;
    logic        pending;
    logic [9:0]  pend_val;

    logic [19:0] presc;
    logic [1:0]  idx;
    logic [3:0]  nib;
    logic [3:0]  blank;
    logic [6:0]  seg_raw;

    // Add-3 correction on each BCD nibble ahead of the shift. Each add is
    // confined to its own nibble; no carry crosses into the next digit.
    always_comb begin
        // NOTE: default every combinational output first so no path leaves it unassigned (no latch).
        shift_adj = shift;
        for (int n = 0; n < 4; n++) begin
            if (shift[10 + 4*n +: 4] >= 4'd5)
                shift_adj[10 + 4*n +: 4] = shift[10 + 4*n +: 4] + 4'd3;
        end
    end

    // Conversion FSM: owns the shift register, the iteration count, the
    // pending request, the committed digits and the done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            shift    <= '0;
            iter     <= '0;
            pending  <= 1'b0;
            pend_val <= '0;
            digits   <= '0;
            done     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        shift <= {16'd0, number};
                        iter  <= '0;
                        state <= SHIFT;
                    end
                end

                SHIFT: begin
                    shift <= {shift_adj[24:0], 1'b0};
                    if (load) begin
                        pending  <= 1'b1;
                        pend_val <= number;
                    end
                    if (iter == LAST_ITER) begin
                        state <= COMMIT;
                    end else begin
                        iter <= iter + 4'd1;
                    end
                end

                COMMIT: begin
                    digits <= shift[25:10];
                    done   <= 1'b1;
                    iter   <= '0;
                    if (pending) begin
                        // Start the queued value; a load arriving in this very
                        // cycle becomes the new queued request.
                        shift    <= {16'd0, pend_val};
                        pending  <= load;
                        if (load)
                            pend_val <= number;
                        state    <= SHIFT;
                    end else if (load) begin
                        // A request landing in COMMIT with an empty queue
                        // would otherwise be picked up by IDLE one cycle
                        // later; starting it here gives the same result sooner.
                        shift <= {16'd0, number};
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign dp   = 1'b1;

    // Free-running refresh prescaler; each terminal count advances the digit index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
            idx   <= '0;
        end else if (presc == PRESC_LAST) begin
            presc <= '0;
            idx   <= idx + 2'd1;
        end else begin
            presc <= presc + 20'd1;
        end
    end

    assign an  = ~(4'b0001 << idx);
    assign nib = digits[{idx, 2'b00} +: 4];

    // Leading-zero mask: a digit is blank when it and every higher digit are zero.
    always_comb begin
        blank    = 4'b0000;
        blank[3] = (digits[15:12] == 4'd0);
        blank[2] = blank[3] && (digits[11:8] == 4'd0);
        blank[1] = blank[2] && (digits[7:4] == 4'd0);
        if (!BLANK_LEADING)
            blank = 4'b0000;
    end

    // Active-low segment decode (bit order g..a); codes 10-15 decode as blank.
    always_comb begin
        case (nib)
            4'd0:    seg_raw = 7'b1000000;
            4'd1:    seg_raw = 7'b1111001;
            4'd2:    seg_raw = 7'b0100100;
            4'd3:    seg_raw = 7'b0110000;
            4'd4:    seg_raw = 7'b0011001;
            4'd5:    seg_raw = 7'b0010010;
            4'd6:    seg_raw = 7'b0000010;
            4'd7:    seg_raw = 7'b1111000;
            4'd8:    seg_raw = 7'b0000000;
            4'd9:    seg_raw = 7'b0010000;
            default: seg_raw = 7'b1111111;
        endcase
    end

    // Index and digits are both registers, so seg and an switch on the same edge.
    assign seg = blank[idx] ? 7'b1111111 : seg_raw;

endmodule
